hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: opcode_ID  input  6  opcode of instruction in ID.
REQ-004 SHALL have ports: rs_ID and rt_ID  input  5 each  source registers of ID instruction.
REQ-005 SHALL have port: dest_ID  input  5  RegDst-resolved write register of ID instruction.
REQ-006 SHALL have port: CtrlSig_ID  input  8  {RegWrite,MemtoReg,MemRead,MemWrite,RegDst,ALUOp[1:0],ALUSrc} from decoder.
REQ-007 SHALL have port: IF_flush  input  1  flush request from decoder.
REQ-008 SHALL have ports: IF_ID_write and PC_write  output  1 each  1 = advance, 0 = hold.
REQ-009 SHALL have port: ID_EX_bubble  output  1  1 = load all-zero control into ID/EX.
REQ-010 SHALL have ports: stall_cnt and flush_cnt  output  16 each  saturating event counters.

Function
REQ-011 SHALL keep shadow stages EX {rd, regwrite, memread} and MEM {rd, regwrite, memread}, updated every cycle: MEM<=EX; EX<=ID info, or all-zero when ID_EX_bubble=1.
REQ-012 SHALL derive uses_rt=1 for opcodes 000000, 000100, 000101, 101011; uses_rs=1 for all opcodes except 000010.
REQ-013 SHALL flag load-use hazard when EX.memread=1, EX.rd!=0, and EX.rd matches a used source of ID.
REQ-014 SHALL flag branch hazard when opcode_ID is 000100/000101 and either EX.regwrite=1 with EX.rd!=0 matching rs_ID/rt_ID, or MEM.memread=1 with MEM.rd!=0 matching rs_ID/rt_ID.
REQ-015 SHALL drive stall=load-use OR branch hazard, combinationally from shadow state and ID inputs, same cycle.
REQ-016 SHALL drive, on stall: IF_ID_write=0, PC_write=0, ID_EX_bubble=1; otherwise 1, 1, 0.
REQ-017 SHALL resolve lw-then-branch by two consecutive stall cycles, the second arising naturally from MEM shadow; no additional state.
REQ-018 SHALL ignore register $0 for all hazard matches.
REQ-019 SHALL increment stall_cnt in each stall cycle; saturate at 0xFFFF, no wrap.
REQ-020 SHALL increment flush_cnt when IF_flush=1 and IF_ID_write=1 in the same cycle; saturate at 0xFFFF.
REQ-021 SHALL, on simultaneous stall and IF_flush, give stall priority; flush_cnt not incremented.

Reset
REQ-022 SHALL, while reset=1, drive IF_ID_write=0, PC_write=0, ID_EX_bubble=1.
REQ-023 SHALL, on a clk edge with reset=1, clear both shadow stages and both counters to 0.
REQ-024 SHALL, in first cycle after reset release, drive IF_ID_write=1, PC_write=1, ID_EX_bubble=0 unless a hazard from new ID inputs exists.
REQ-025 SHALL, on reset asserted mid-stall, abandon the stall; no pending stall survives reset.

Structure
REQ-026 SHALL take opcode constants (R, addi, andi, beq, bne, j, lw, sw) and CtrlSig bit indices from shared package pipe_pkg.
REQ-027 SHALL instantiate sub-module hazard_shadow_stage twice (EX, MEM): 11-bit register with sync clear and zero-load input.

Verification
REQ-028 SHALL test lw $2,0($1) then add $3,$2,$4 -> exactly 1 stall cycle, stall_cnt=1, add in EX one cycle late.
REQ-029 SHALL test addi $5,$0,1 then beq $5,$0 -> 1 stall cycle; addi then unrelated beq $6,$7 -> 0 stalls.
REQ-030 SHALL test lw $6,0($1) then beq $6,$7 -> 2 consecutive stall cycles, stall_cnt=2.
REQ-031 SHALL test lw $0,0($1) then add $3,$0,$0 -> no stall.
REQ-032 SHALL test reset asserted in stall cycle -> outputs 0/0/1 during reset; next cycle after release 1/1/0, counters=0.
REQ-033 SHALL test j with IF_flush=1 repeated 0x10000 times -> flush_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, decoder control-bit positions and the
// per-stage hazard bookkeeping record.
package pipe_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // Bit positions inside CtrlSig = {RegWrite,MemtoReg,MemRead,MemWrite,RegDst,ALUOp[1:0],ALUSrc}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUSRC   = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       regdst;
        logic       alusrc;
    } shadow_t;

    localparam int SHADOW_W = $bits(shadow_t);

    // A source register collides with a pending write only when neither is $0.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] rd);
        return (rd != 5'd0) && (src == rd);
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline register tracking what a downstream stage will write.
// Synchronous clear has priority over the zero-load (bubble) input.
module hazard_shadow_stage #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_zero,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage register: clear, bubble, or capture.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load_zero) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use and branch-operand hazard detection with stall/flush event counters.
// Stall decisions are combinational from the shadow EX/MEM state and ID inputs.
import pipe_pkg::*;

module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode_ID,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic [4:0]  dest_ID,
    input  logic [7:0]  CtrlSig_ID,
    input  logic        IF_flush,
    output logic        IF_ID_write,
    output logic        PC_write,
    output logic        ID_EX_bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    shadow_t     id_s;
    shadow_t     ex_s;
    shadow_t     mem_s;
    logic        uses_rs_s;
    logic        uses_rt_s;
    logic        is_branch_s;
    logic        load_use_s;
    logic        branch_haz_s;
    logic        stall_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    assign id_s = '{rd:       dest_ID,
                    regwrite: CtrlSig_ID[CTRL_REGWRITE],
                    memtoreg: CtrlSig_ID[CTRL_MEMTOREG],
                    memread:  CtrlSig_ID[CTRL_MEMREAD],
                    memwrite: CtrlSig_ID[CTRL_MEMWRITE],
                    regdst:   CtrlSig_ID[CTRL_REGDST],
                    alusrc:   CtrlSig_ID[CTRL_ALUSRC]};

    hazard_shadow_stage #(.WIDTH(SHADOW_W)) u_ex (
        .clk       (clk),
        .clear     (reset),
        .load_zero (ID_EX_bubble),
        .d         (id_s),
        .q         (ex_s)
    );

    hazard_shadow_stage #(.WIDTH(SHADOW_W)) u_mem (
        .clk       (clk),
        .clear     (reset),
        .load_zero (1'b0),
        .d         (ex_s),
        .q         (mem_s)
    );

    // Which source fields the ID instruction actually reads.
    always_comb begin
        uses_rt_s   = 1'b0;
        is_branch_s = 1'b0;
        case (opcode_ID)
            OP_R, OP_SW: uses_rt_s = 1'b1;
            OP_BEQ, OP_BNE: begin
                uses_rt_s   = 1'b1;
                is_branch_s = 1'b1;
            end
            default: uses_rt_s = 1'b0;
        endcase
        uses_rs_s = (opcode_ID != OP_J);
    end

    // Hazard detection; a lw feeding a branch stalls twice (EX, then MEM match).
    always_comb begin
        load_use_s = ex_s.memread &&
                     ((uses_rs_s && reg_hit(rs_ID, ex_s.rd)) ||
                      (uses_rt_s && reg_hit(rt_ID, ex_s.rd)));
        branch_haz_s = is_branch_s &&
                       ((ex_s.regwrite && (reg_hit(rs_ID, ex_s.rd) || reg_hit(rt_ID, ex_s.rd))) ||
                        (mem_s.memread && (reg_hit(rs_ID, mem_s.rd) || reg_hit(rt_ID, mem_s.rd))));
        stall_s = load_use_s || branch_haz_s;
    end

    // Pipeline control; reset holds the front end and injects bubbles.
    always_comb begin
        IF_ID_write  = 1'b1;
        PC_write     = 1'b1;
        ID_EX_bubble = 1'b0;
        if (reset || stall_s) begin
            IF_ID_write  = 1'b0;
            PC_write     = 1'b0;
            ID_EX_bubble = 1'b1;
        end else begin
            IF_ID_write  = 1'b1;
            PC_write     = 1'b1;
            ID_EX_bubble = 1'b0;
        end
    end

    // Saturating event counters; a stalled flush is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (IF_flush && IF_ID_write && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction pairs with hand-computed stall
// behaviour, reset during a stall and flush counter saturation.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode_ID;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic [4:0]  dest_ID;
    logic [7:0]  CtrlSig_ID;
    logic        IF_flush;
    logic        IF_ID_write;
    logic        PC_write;
    logic        ID_EX_bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] C_R    = 8'b1000_1100;
    localparam logic [7:0] C_LW   = 8'b1110_0001;
    localparam logic [7:0] C_ADDI = 8'b1000_0001;
    localparam logic [7:0] C_BR   = 8'b0000_0010;
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [2:0] RUN    = 3'b110;
    localparam logic [2:0] HOLD   = 3'b001;

    hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_ID    (opcode_ID),
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .dest_ID      (dest_ID),
        .CtrlSig_ID   (CtrlSig_ID),
        .IF_flush     (IF_flush),
        .IF_ID_write  (IF_ID_write),
        .PC_write     (PC_write),
        .ID_EX_bubble (ID_EX_bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [7:0] ctl, input logic fl);
        opcode_ID  = op;
        rs_ID      = rs;
        rt_ID      = rt;
        dest_ID    = dst;
        CtrlSig_ID = ctl;
        IF_flush   = fl;
    endtask

    task automatic nop();
        set_id(6'b000000, 5'd0, 5'd0, 5'd0, C_NONE, 1'b0);
    endtask

    // Check the {IF_ID_write, PC_write, ID_EX_bubble} triple mid-cycle.
    task automatic ctl(input string tag, input logic [2:0] exp);
        @(negedge clk);
        chk(tag, {29'd0, IF_ID_write, PC_write, ID_EX_bubble}, {29'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop(); tick();
        nop(); tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        ctl("reset_ctl", HOLD);
        tick();
        tick();
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        reset = 1'b0;

        // lw $2,0($1) ; add $3,$2,$4
        set_id(6'b100011, 5'd1, 5'd2, 5'd2, C_LW, 1'b0);
        ctl("lw_add_first", RUN);
        tick();
        set_id(6'b000000, 5'd2, 5'd4, 5'd3, C_R, 1'b0);
        ctl("lw_add_stall", HOLD);
        tick();
        ctl("lw_add_retry", RUN);
        chk("lw_add_ex_bubble", {27'd0, dut.ex_s.rd}, 32'd0);
        tick();
        nop();
        @(negedge clk);
        chk("lw_add_ex_late", {27'd0, dut.ex_s.rd}, 32'd3);
        chk("lw_add_cnt", {16'd0, stall_cnt}, 32'd1);
        tick();
        drain();

        // addi $5,$0,1 ; beq $5,$0
        set_id(6'b001000, 5'd0, 5'd5, 5'd5, C_ADDI, 1'b0);
        ctl("addi_beq_first", RUN);
        tick();
        set_id(6'b000100, 5'd5, 5'd0, 5'd0, C_BR, 1'b0);
        ctl("addi_beq_stall", HOLD);
        tick();
        ctl("addi_beq_retry", RUN);
        tick();
        chk("addi_beq_cnt", {16'd0, stall_cnt}, 32'd2);
        drain();

        // addi $5 ; beq $6,$7 (unrelated)
        set_id(6'b001000, 5'd0, 5'd5, 5'd5, C_ADDI, 1'b0);
        tick();
        set_id(6'b000100, 5'd6, 5'd7, 5'd0, C_BR, 1'b0);
        ctl("addi_unrel_beq", RUN);
        tick();
        drain();
        chk("unrel_cnt", {16'd0, stall_cnt}, 32'd2);

        // lw $6,0($1) ; beq $6,$7 -> two stalls
        set_id(6'b100011, 5'd1, 5'd6, 5'd6, C_LW, 1'b0);
        ctl("lw_beq_first", RUN);
        tick();
        set_id(6'b000100, 5'd6, 5'd7, 5'd0, C_BR, 1'b0);
        ctl("lw_beq_stall1", HOLD);
        tick();
        ctl("lw_beq_stall2", HOLD);
        tick();
        ctl("lw_beq_go", RUN);
        tick();
        chk("lw_beq_cnt", {16'd0, stall_cnt}, 32'd4);
        drain();

        // lw $0,0($1) ; add $3,$0,$0
        set_id(6'b100011, 5'd1, 5'd0, 5'd0, C_LW, 1'b0);
        tick();
        set_id(6'b000000, 5'd0, 5'd0, 5'd3, C_R, 1'b0);
        ctl("lw_r0_add", RUN);
        tick();
        drain();

        // lw $2 ; j with rs field = 2 (j reads no register)
        set_id(6'b100011, 5'd1, 5'd2, 5'd2, C_LW, 1'b0);
        tick();
        set_id(6'b000010, 5'd2, 5'd2, 5'd0, C_NONE, 1'b0);
        ctl("lw_j_no_rs", RUN);
        tick();
        drain();

        // lw $2 ; addi $9,$4 whose rt field is 2 (addi writes rt, reads rs only)
        set_id(6'b100011, 5'd1, 5'd2, 5'd2, C_LW, 1'b0);
        tick();
        set_id(6'b001000, 5'd4, 5'd2, 5'd2, C_ADDI, 1'b0);
        ctl("lw_addi_no_rt", RUN);
        tick();
        drain();
        chk("no_rt_cnt", {16'd0, stall_cnt}, 32'd4);

        // Reset asserted while stalling
        set_id(6'b100011, 5'd1, 5'd2, 5'd2, C_LW, 1'b0);
        tick();
        set_id(6'b000000, 5'd2, 5'd4, 5'd3, C_R, 1'b0);
        ctl("pre_reset_stall", HOLD);
        reset = 1'b1;
        #1;
        chk("mid_stall_reset", {29'd0, IF_ID_write, PC_write, ID_EX_bubble}, {29'd0, HOLD});
        tick();
        reset = 1'b0;
        ctl("after_reset_run", RUN);
        chk("after_reset_scnt", {16'd0, stall_cnt}, 32'd0);
        chk("after_reset_fcnt", {16'd0, flush_cnt}, 32'd0);
        tick();
        drain();

        // Stall and flush together: stall wins, no flush counted
        set_id(6'b100011, 5'd1, 5'd2, 5'd2, C_LW, 1'b0);
        tick();
        set_id(6'b000000, 5'd2, 5'd4, 5'd3, C_R, 1'b1);
        ctl("stall_flush_ctl", HOLD);
        tick();
        nop();
        @(negedge clk);
        chk("stall_flush_fcnt", {16'd0, flush_cnt}, 32'd0);
        tick();

        // j with IF_flush, 0x10000 times
        set_id(6'b000010, 5'd0, 5'd0, 5'd0, C_NONE, 1'b1);
        tick();
        chk("flush_first", {16'd0, flush_cnt}, 32'd1);
        for (int i = 1; i < 32'h10000; i++) begin
            if (i == 32'hFFFE) begin
                chk("flush_fffe", {16'd0, flush_cnt}, 32'hFFFE);
            end
            tick();
        end
        chk("flush_sat", {16'd0, flush_cnt}, 32'hFFFF);
        tick();
        chk("flush_sat_hold", {16'd0, flush_cnt}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
